// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker instruction fetch path.
package tinker_pkg;

    // Major opcode of the halt instruction (bits [31:27] of the word).
    localparam logic [4:0] OP_HALT = 5'h0f;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // True when the instruction word carries the halt opcode.
    function automatic logic is_halt(input logic [31:0] word);
        return (word[31:27] == OP_HALT);
    endfunction

endpackage

// File: rtl/tinker_sync_fifo.sv
// Synchronous circular queue with push/pop/flush. The head entry is read
// straight from storage; a pushed entry becomes visible one cycle later.
module tinker_sync_fifo
    import tinker_pkg::*;
#(
    parameter type         T     = fetch_entry_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       din,
    output T                       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Next pointers, occupancy and storage; flush empties the queue and beats push/pop.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && (count_q != DEPTH_C);
        do_pop_s  = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
        end
    end

    // State registers; storage is cleared on reset so the head reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

endmodule

// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch queue in front of the tinker decoder.
// Issues in-order word reads, buffers {pc, word} pairs, and restarts on redirect.
// Optional build macro TINKER_FETCH_HALT_STOP_EN: stop fetching once a halt
// instruction has been enqueued (cleared by redirect or reset).
module tinker_fetch_queue
    import tinker_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // Stale-response counter; must cover every response outstanding across
    // back-to-back redirects for the worst-case memory latency.
    localparam int unsigned DW = 8;

    addr_t        fetch_pc_q;
    addr_t        fetch_pc_d;
    addr_t        ret_pc_q;
    addr_t        ret_pc_d;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;
    logic [DW-1:0] drop_q;
    logic [DW-1:0] drop_d;
    logic          halted_q;
    logic          halted_d;

    logic [CW-1:0] count_s;
    logic          full_s;
    logic          empty_s;
    logic          credit_s;
    logic          live_rsp_s;
    logic          push_s;
    logic          pop_s;
    fetch_entry_t  head_s;
    fetch_entry_t  push_entry_s;

    // Only live (non-stale) requests consume queue credit.
    assign credit_s     = ({1'b0, count_s} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
    assign imem_req     = !reset && !redirect_valid && !halted_q && credit_s;
    assign imem_addr    = fetch_pc_q;
    assign live_rsp_s   = imem_rvalid && (drop_q == '0);
    assign push_s       = live_rsp_s && !redirect_valid && !full_s;
    assign pop_s        = inst_valid && inst_ready;
    assign push_entry_s = '{pc: ret_pc_q, word: imem_rdata};

    // Next fetch/return PCs and request accounting; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        halted_d   = halted_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            ret_pc_d   = redirect_pc;
            // Every outstanding response becomes stale, minus one arriving now.
            drop_d     = DW'(inflight_q) + drop_q - DW'(imem_rvalid);
            inflight_d = '0;
            halted_d   = 1'b0;
        end else begin
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - DW'(1);
            end else begin
                drop_d = drop_q;
            end
            if (live_rsp_s) begin
                ret_pc_d = ret_pc_q + 32'd4;
            end else begin
                ret_pc_d = ret_pc_q;
            end
            inflight_d = inflight_q + CW'(imem_req) - CW'(live_rsp_s);
`ifdef TINKER_FETCH_HALT_STOP_EN
            // A halt entering the queue stops fetch; anything still in flight is stale.
            if (push_s && is_halt(imem_rdata)) begin
                halted_d   = 1'b1;
                drop_d     = drop_d + DW'(inflight_d);
                inflight_d = '0;
            end else begin
                halted_d = halted_q;
            end
`else
            halted_d = 1'b0;
`endif
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            ret_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            halted_q   <= halted_d;
        end
    end

    tinker_sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .din   (push_entry_s),
        .dout  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign inst_valid = !empty_s;
    assign inst_word  = head_s.word;
    assign inst_pc    = head_s.pc;

endmodule
